// File: rtl/flash_prog_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// flash_prog_ctrl_pkg
// Shared definitions for the flash programming controller: AXI widths,
// response/protection/strobe constants and the controller state encoding.
// -----------------------------------------------------------------------------
package flash_prog_ctrl_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;
   localparam int FLASH_CNT_W    = 18;   // covers the full 81920-word array

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [2:0] AXI_PROT_NONE = 3'b000;
   localparam logic [3:0] AXI_STRB_FULL = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COLLECT  = 3'd1,
      ST_WR       = 3'd2,
      ST_WR_RESP  = 3'd3,
      ST_RD_ADDR  = 3'd4,
      ST_RD_DATA  = 3'd5,
      ST_FINISH   = 3'd6
   } fsm_state_e;

endpackage

// File: rtl/flash_byte_packer.sv
// -----------------------------------------------------------------------------
// flash_byte_packer
// Accepts bytes on a valid/ready stream and packs four of them little-endian
// into a 32-bit word (first byte in [7:0]).
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   clear_i           drop any partially collected word
//   en_i              collection enabled (drives byte_ready_o)
//   byte_valid_i/byte_ready_o/byte_i   byte stream handshake
//   word_valid_o      the 4th byte of a word is being accepted this cycle
//   word_o            the complete word, valid together with word_valid_o
//   word_ack_i        consumer takes the word; restarts the byte index
// -----------------------------------------------------------------------------
module flash_byte_packer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic        word_ack_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        byte_ready_o,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [1:0]  idx_q;
   logic [23:0] data_q;   // bytes 0..2; byte 3 is taken straight from the bus
   logic        fire;

   assign byte_ready_o = en_i;
   assign fire         = en_i & byte_valid_i;
   // Word completes in the same cycle its last byte is accepted, so the
   // controller can move on right at that edge.
   assign word_valid_o = fire & (idx_q == 2'd3);
   assign word_o       = {byte_i, data_q};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q  <= 2'd0;
         data_q <= '0;
      end else if (clear_i) begin
         idx_q  <= 2'd0;
         data_q <= '0;
      end else begin
         if (fire) begin
            case (idx_q)
               2'd0:    data_q[7:0]   <= byte_i;
               2'd1:    data_q[15:8]  <= byte_i;
               2'd2:    data_q[23:16] <= byte_i;
               default: ;
            endcase
         end
         if (word_ack_i)
            idx_q <= 2'd0;
         else if (fire)
            idx_q <= idx_q + 2'd1;
      end
   end

endmodule

// File: rtl/flash_prog_ctrl.sv
// -----------------------------------------------------------------------------
// flash_prog_ctrl
// AXI4-lite master that programs flash from a byte stream. A job (base address,
// word count, verify flag) is latched on start; bytes are packed into words,
// each word is written with one AXI write and optionally read back and compared.
//
// Ports:
//   ACLK, ARESET                 clock, asynchronous active-high reset
//   start/base_addr/word_cnt/verify_en   job request (start ignored while busy)
//   s_byte_valid/s_byte_ready/s_byte     byte stream
//   busy, done, error, err_addr  job status (error sticky until next start)
//   M_AW*, M_W*, M_B*, M_AR*, M_R*       AXI4-lite master channels
// -----------------------------------------------------------------------------
module flash_prog_ctrl
   import flash_prog_ctrl_pkg::*;
#(
   parameter int ADDR_W = AXI_ADDR_WIDTH,
   parameter int DATA_W = AXI_DATA_WIDTH,   // only 32 is supported
   parameter int CNT_W  = FLASH_CNT_W
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_cnt,
   input  logic              verify_en,
   input  logic              s_byte_valid,
   output logic              s_byte_ready,
   input  logic [7:0]        s_byte,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr,
   output logic              M_AWVALID,
   input  logic              M_AWREADY,
   output logic [ADDR_W-1:0] M_AWADDR,
   output logic [2:0]        M_AWPROT,
   output logic              M_WVALID,
   input  logic              M_WREADY,
   output logic [DATA_W-1:0] M_WDATA,
   output logic [3:0]        M_WSTRB,
   input  logic              M_BVALID,
   output logic              M_BREADY,
   input  logic [1:0]        M_BRESP,
   output logic              M_ARVALID,
   input  logic              M_ARREADY,
   output logic [ADDR_W-1:0] M_ARADDR,
   output logic [2:0]        M_ARPROT,
   input  logic              M_RVALID,
   output logic              M_RREADY,
   input  logic [DATA_W-1:0] M_RDATA,
   input  logic [1:0]        M_RRESP
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   fsm_state_e        state_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [CNT_W-1:0]  remaining_q;
   logic              verify_q;
   logic [DATA_W-1:0] wdata_q;
   logic              awvalid_q, wvalid_q;
   logic              aw_done_q, w_done_q;
   logic              bready_q, arvalid_q, rready_q;
   logic              busy_q, done_q, error_q;
   logic [ADDR_W-1:0] err_addr_q;

   logic              aw_hs, w_hs, last_word;
   logic              pack_clear, pack_en, pack_word_valid;
   logic [31:0]       pack_word;

   assign aw_hs      = awvalid_q & M_AWREADY;
   assign w_hs       = wvalid_q & M_WREADY;
   assign last_word  = (remaining_q == CNT_W'(1));
   assign pack_en    = (state_q == ST_COLLECT);
   assign pack_clear = (state_q == ST_IDLE) & start;

   flash_byte_packer u_packer (
      .clk_i        (ACLK),
      .rst_i        (ARESET),
      .clear_i      (pack_clear),
      .en_i         (pack_en),
      .word_ack_i   (pack_word_valid),
      .byte_valid_i (s_byte_valid),
      .byte_i       (s_byte),
      .byte_ready_o (s_byte_ready),
      .word_valid_o (pack_word_valid),
      .word_o       (pack_word)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= ST_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         verify_q    <= 1'b0;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cur_addr_q  <= base_addr & ALIGN_MASK;
                  remaining_q <= word_cnt;
                  verify_q    <= verify_en;
                  error_q     <= 1'b0;
                  err_addr_q  <= '0;
                  if (word_cnt == '0) begin
                     // Empty job: report completion without touching the bus.
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= ST_COLLECT;
                  end
               end
            end

            ST_COLLECT: begin
               if (pack_word_valid) begin
                  wdata_q   <= pack_word;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  state_q   <= ST_WR;
               end
            end

            ST_WR: begin
               // AW and W complete independently; each VALID drops right after
               // its own handshake, the state waits for both.
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                  bready_q <= 1'b1;
                  state_q  <= ST_WR_RESP;
               end
            end

            ST_WR_RESP: begin
               if (M_BVALID) begin
                  bready_q <= 1'b0;
                  if (M_BRESP != AXI_RESP_OKAY) begin
                     error_q    <= 1'b1;
                     err_addr_q <= cur_addr_q;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= ST_FINISH;
                  end else if (verify_q) begin
                     arvalid_q <= 1'b1;
                     state_q   <= ST_RD_ADDR;
                  end else begin
                     remaining_q <= remaining_q - CNT_W'(1);
                     cur_addr_q  <= cur_addr_q + ADDR_W'(4);
                     if (last_word) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                     end else begin
                        state_q <= ST_COLLECT;
                     end
                  end
               end
            end

            ST_RD_ADDR: begin
               if (M_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RD_DATA;
               end
            end

            ST_RD_DATA: begin
               if (M_RVALID) begin
                  rready_q <= 1'b0;
                  if ((M_RRESP != AXI_RESP_OKAY) || (M_RDATA != wdata_q)) begin
                     error_q    <= 1'b1;
                     err_addr_q <= cur_addr_q;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= ST_FINISH;
                  end else begin
                     remaining_q <= remaining_q - CNT_W'(1);
                     cur_addr_q  <= cur_addr_q + ADDR_W'(4);
                     if (last_word) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                     end else begin
                        state_q <= ST_COLLECT;
                     end
                  end
               end
            end

            ST_FINISH: state_q <= ST_IDLE;

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_addr  = err_addr_q;
   assign M_AWVALID = awvalid_q;
   assign M_AWADDR  = cur_addr_q;
   assign M_AWPROT  = AXI_PROT_NONE;
   assign M_WVALID  = wvalid_q;
   assign M_WDATA   = wdata_q;
   // Full strobe whenever data is offered; zero out of reset.
   assign M_WSTRB   = wvalid_q ? AXI_STRB_FULL : 4'h0;
   assign M_BREADY  = bready_q;
   assign M_ARVALID = arvalid_q;
   assign M_ARADDR  = cur_addr_q;
   assign M_ARPROT  = AXI_PROT_NONE;
   assign M_RREADY  = rready_q;

endmodule

// File: doc/flash_prog_ctrl.md
Name: flash_prog_ctrl

Overview:
AXI4-lite master that programs the flash_sim memory model from a byte stream, for example one fed by the UART boot path. Software or the testbench gives a base address and a word count, then streams bytes. The block packs the bytes little-endian into 32-bit words and issues one AXI4-lite write per word. With verify enabled, it reads each word back and compares it. It sits between the boot loader source and the flash slave port, and it is the only master that sequences that slave during programming.

Parameters:
ADDR_W, `AXI_ADDR_WIDTH (32), AXI address width
DATA_W, `AXI_DATA_WIDTH (32), AXI data width; fixed at 32, other values unsupported
CNT_W, 18, word-count width; covers the full 81920-word array

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; latches base_addr, word_cnt and verify_en; ignored while busy
base_addr  in  ADDR_W  first word address; bits [1:0] ignored (treated as 0)
word_cnt  in  CNT_W  number of words to program
verify_en  in  1  enables read-back compare after each write
s_byte_valid / s_byte_ready / s_byte  in / out / in  1/1/8  byte stream, valid/ready handshake
busy  out  1  high from the cycle after start until the cycle done pulses
done  out  1  one-cycle pulse at the end of a job, on success or error
error  out  1  sticky; cleared by the next accepted start
err_addr  out  ADDR_W  address of the failing word; valid while error=1
M_AWVALID / M_AWREADY / M_AWADDR / M_AWPROT  out/in/out/out  1/1/ADDR_W/3  write address channel
M_WVALID / M_WREADY / M_WDATA / M_WSTRB  out/in/out/out  1/1/DATA_W/4  write data channel
M_BVALID / M_BREADY / M_BRESP  in/out/in  1/1/2  write response channel
M_ARVALID / M_ARREADY / M_ARADDR / M_ARPROT  out/in/out/out  1/1/ADDR_W/3  read address channel
M_RVALID / M_RREADY / M_RDATA / M_RRESP  in/out/in/in  1/1/DATA_W/2  read data channel

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; FSM to IDLE; any in-flight AXI transaction is abandoned.
- Constants: AWPROT = ARPROT = 3'b000; WSTRB = 4'hF.
- States: IDLE, COLLECT, WR, WR_RESP, RD_ADDR, RD_DATA, FINISH.
- IDLE:
  - start with word_cnt != 0 -> COLLECT; latch cur_addr = {base_addr[ADDR_W-1:2], 2'b00} and remaining = word_cnt.
  - start with word_cnt == 0 -> FINISH; no AXI traffic.
- COLLECT:
  - s_byte_ready = 1 only in this state.
  - Byte k (k = 0..3) goes to wdata[8k+7:8k]; first byte received lands in [7:0].
  - The 4th accepted byte -> WR next cycle.
- WR:
  - AWVALID and WVALID rise together, with AWADDR = cur_addr and WDATA = the packed word.
  - Each VALID falls the cycle after its own handshake; the two channels complete independently and in either order.
  - Address and data are held stable while VALID is high.
  - When both handshakes are done -> WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID with BRESP != 2'b00 -> error = 1, err_addr = cur_addr, -> FINISH.
  - On BVALID with OKAY -> RD_ADDR if verify is latched, else go to NEXT.
- RD_ADDR: ARVALID = 1 with ARADDR = cur_addr, held until ARREADY; then -> RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, if RRESP != OKAY or RDATA != the packed word -> error, err_addr = cur_addr, -> FINISH; else NEXT.
- NEXT (transition, not a state):
  - remaining decrements; cur_addr += 4, wrapping modulo 2^ADDR_W.
  - remaining reaching 0 -> FINISH, else -> COLLECT.
- FINISH: done = 1 for one cycle, busy = 0 on that same cycle, -> IDLE.
- Error abort: bytes not yet consumed stay unconsumed (s_byte_ready stays low); the source must flush them.
- A start pulse arriving in any state other than IDLE has no effect.
- Latency, ideal slave (READY high, BVALID/RVALID one cycle after handshake), per word after the 4th byte:
  - WR 1 cycle, WR_RESP 2 cycles;
  - with verify, add RD_ADDR 1 cycle and RD_DATA 2 cycles.

Decomposition:
- Shared package / `top_defines.vh`: AXI width macros (existing), AXI_RESP_OKAY = 2'b00, FSM state encoding localparams.
- One natural sub-module: flash_byte_packer.
  - Byte handshake, 2-bit byte index, 32-bit shift/assemble register.
  - Outputs word_valid; takes word_ack from the FSM and a clear input.
- The top level holds the FSM, address and count registers, AXI channel drivers and the compare logic.

Test Plan:
1. base 0x100, cnt 2, verify off, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211 @0x100 and 0x88776655 @0x104, WSTRB F; done pulse; error 0; exactly 2 AW, W and B handshakes.
2. Same job with verify on, against flash_sim -> ARs at 0x100 and 0x104 return matching data; done pulse; error 0.
3. Verify on; slave corrupts RDATA of the second word -> error 1, err_addr 0x104, done pulse; no further AW; s_byte_ready low.
4. Slave delays AWREADY 3 cycles after WREADY, then the reverse -> one handshake per channel; each VALID drops independently; AWADDR/WDATA stable while VALID high.
5. BRESP 2'b10 on the first word (base 0x0) -> error 1, err_addr 0x0, done; a following start clears error and the job completes.
6. start with cnt 0 -> done pulse, no AXI activity; a separate job asserting ARESET while AWVALID is high -> all outputs 0 asynchronously, FSM in IDLE.
